alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrate, execute one op, hold the response.
// Define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins).
module alu_arbiter #(
    parameter int WIDTH       = 16,
    parameter int ST_NEG      = 3,
    parameter int ST_ZERO     = 2,
    parameter int ST_CARRY    = 1,
    parameter int ST_OVERFLOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       req_ack,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_status,
    input  logic             rsp_ready
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_d;

    logic             win;
    logic             take;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   ext;
    logic             carry;
    logic             ovf;
    logic [3:0]       st;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    // Requester 0 always wins; requester 1 only when alone.
    always_comb begin
        win = ~req_valid[0];
    end
`else
    logic last;

    // Round-robin: on contention the requester not granted last wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            win = ~last;
        end else begin
            win = req_valid[1];
        end
    end

    // Remember who was granted; reset favours requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= win;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and acceptance; ack is a pulse during the accepting IDLE cycle.
    always_comb begin
        state_d = state;
        take    = 1'b0;
        req_ack = 2'b00;
        unique case (state)
            IDLE: begin
                if (|req_valid && !rst) begin
                    take    = 1'b1;
                    state_d = EXEC;
                    req_ack = win ? 2'b10 : 2'b01;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's opcode and operands at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 3'd0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (take) begin
            id_q <= win;
            op_q <= win ? req_op1 : req_op0;
            a_q  <= win ? req_a1 : req_a0;
            b_q  <= win ? req_b1 : req_b0;
        end
    end

    // ALU and status flags; unknown opcodes pass operand1 through.
    always_comb begin
        res   = a_q;
        ext   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (op_q)
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_ADD: begin
                ext   = {1'b0, a_q} + {1'b0, b_q};
                res   = ext[MSB:0];
                carry = ext[WIDTH];
                ovf   = (a_q[MSB] == b_q[MSB])
                      && (res[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                ext   = {1'b0, a_q} - {1'b0, b_q};
                res   = ext[MSB:0];
                carry = ext[WIDTH];
                ovf   = (a_q[MSB] != b_q[MSB])
                      && (res[MSB] != a_q[MSB]);
            end
            OP_NOT: res = ~a_q;
            default: res = a_q;
        endcase
        st              = 4'b0000;
        st[ST_NEG]      = res[MSB];
        st[ST_ZERO]     = (res == '0);
        st[ST_CARRY]    = carry;
        st[ST_OVERFLOW] = ovf;
    end

    // Response registers: load in EXEC, hold through RESP until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_status <= 4'b0000;
        end else if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= res;
            rsp_status <= st;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
